// File: rtl/jump_controller_pkg.sv
// Shared definitions for the press-to-jump game flow: widths, limits and FSM states.
package jump_controller_pkg;

    localparam int DEF_LEN_W   = 10;
    localparam int DEF_SCORE_W = 16;
    localparam int DEF_STEP    = 8;
    localparam int MAX_LEN     = 800;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_JUMP   = 3'd2,
        ST_LAND   = 3'd3,
        ST_SCORE  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

endpackage

// File: rtl/jump_controller_judge.sv
// Landing judge: |jump_len - gap| <= tolerance, an exact match on the tolerance still hits.
module jump_judge
    import jump_controller_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic [LEN_W-1:0] i_jump_len,
    input  logic [LEN_W-1:0] i_gap,
    input  logic [LEN_W-1:0] i_tol,
    output logic             o_hit
);

    logic signed [LEN_W:0] w_diff;
    logic        [LEN_W:0] w_abs;

    // Signed difference one bit wider than the operands, then magnitude compare.
    always_comb begin
        w_diff = $signed({1'b0, i_jump_len}) - $signed({1'b0, i_gap});
        w_abs  = w_diff[LEN_W] ? LEN_W'(0) - w_diff : w_diff;
        o_hit  = (w_abs <= {1'b0, i_tol});
    end

endmodule

// File: rtl/jump_controller.sv
// Game-flow sequencer: charge, animated jump, landing judgement, scoring and game over.
module jump_controller
    import jump_controller_pkg::*;
#(
    parameter int STEP    = DEF_STEP,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               press,
    input  logic               restart,
    input  logic               frame_tick,
    input  logic [LEN_W-1:0]   length,
    input  logic [LEN_W-1:0]   gap,
    input  logic [LEN_W-1:0]   half_width,
    output logic               press_enable,
    output logic               press_clean,
    output logic [LEN_W-1:0]   man_offset,
    output logic [LEN_W-1:0]   jump_height,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               next_platform
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_offset;
    logic [LEN_W-1:0]   r_jump_len;
    logic [LEN_W-1:0]   r_gap_q;
    logic [LEN_W-1:0]   r_tol_q;
    logic [SCORE_W-1:0] r_score;
    logic               r_press_enable;
    logic               r_press_clean;
    logic               r_game_over;
    logic               r_next_platform;

    logic               w_hit;
    logic [LEN_W:0]     w_sum;
    logic [LEN_W-1:0]   w_remain;
    logic [LEN_W-1:0]   w_min;

    jump_judge #(.LEN_W(LEN_W)) u_judge (
        .i_jump_len (r_jump_len),
        .i_gap      (r_gap_q),
        .i_tol      (r_tol_q),
        .o_hit      (w_hit)
    );

    // Widened step sum so the comparison against jump_len can never wrap.
    always_comb begin
        w_sum = {1'b0, r_offset} + (LEN_W+1)'(STEP);
    end

    // Arc height from the registered offset: half the distance to the nearer end of the jump.
    always_comb begin
        w_remain = r_jump_len - r_offset;
        w_min    = (r_offset < w_remain) ? r_offset : w_remain;
        if (r_state == ST_JUMP || r_state == ST_LAND) begin
            jump_height = w_min >> 1;
        end else begin
            jump_height = '0;
        end
    end

    // Game FSM with offset counter, score and registered Moore outputs (set on state entry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_offset        <= '0;
            r_jump_len      <= '0;
            r_gap_q         <= '0;
            r_tol_q         <= '0;
            r_score         <= '0;
            r_press_enable  <= 1'b0;
            r_press_clean   <= 1'b1;
            r_game_over     <= 1'b0;
            r_next_platform <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_offset <= '0;
                    if (press) begin
                        r_state        <= ST_CHARGE;
                        r_press_enable <= 1'b1;
                        r_press_clean  <= 1'b0;
                    end
                end
                ST_CHARGE: begin
                    if (!press) begin
                        r_jump_len     <= length;
                        r_gap_q        <= gap;
                        r_tol_q        <= half_width;
                        r_press_enable <= 1'b0;
                        if (length == '0) begin
                            r_state       <= ST_IDLE;
                            r_press_clean <= 1'b1;
                        end else begin
                            r_state <= ST_JUMP;
                        end
                    end
                end
                ST_JUMP: begin
                    if (frame_tick) begin
                        if (w_sum >= {1'b0, r_jump_len}) begin
                            r_offset <= r_jump_len;
                            r_state  <= ST_LAND;
                        end else begin
                            r_offset <= w_sum[LEN_W-1:0];
                        end
                    end
                end
                ST_LAND: begin
                    if (w_hit) begin
                        r_state         <= ST_SCORE;
                        r_next_platform <= 1'b1;
                    end else begin
                        r_state       <= ST_OVER;
                        r_game_over   <= 1'b1;
                        r_press_clean <= 1'b1;
                    end
                end
                ST_SCORE: begin
                    r_score         <= (r_score == '1) ? r_score : r_score + 1'b1;
                    r_next_platform <= 1'b0;
                    r_press_clean   <= 1'b1;
                    r_offset        <= '0;
                    r_state         <= ST_IDLE;
                end
                ST_OVER: begin
                    if (restart) begin
                        r_score     <= '0;
                        r_offset    <= '0;
                        r_game_over <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_offset        <= '0;
                    r_press_enable  <= 1'b0;
                    r_press_clean   <= 1'b1;
                    r_game_over     <= 1'b0;
                    r_next_platform <= 1'b0;
                end
            endcase
        end
    end

    assign press_enable  = r_press_enable;
    assign press_clean   = r_press_clean;
    assign man_offset    = r_offset;
    assign score         = r_score;
    assign game_over     = r_game_over;
    assign next_platform = r_next_platform;

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller: directed table, randomized jumps, async reset, saturation.
module tb_jump_controller;

    localparam int STEP  = 8;
    localparam int LEN_W = 10;
    localparam int SAT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             press = 1'b0;
    logic             restart = 1'b0;
    logic             frame_tick = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic [LEN_W-1:0] gap = '0;
    logic [LEN_W-1:0] half_width = '0;

    logic             press_enable, press_clean, game_over, next_platform;
    logic [LEN_W-1:0] man_offset, jump_height;
    logic [15:0]      score;

    logic             press_enable_s, press_clean_s, game_over_s, next_platform_s;
    logic [LEN_W-1:0] man_offset_s, jump_height_s;
    logic [SAT_W-1:0] score_s;

    jump_controller dut (
        .clk(clk), .rst_n(rst_n), .press(press), .restart(restart), .frame_tick(frame_tick),
        .length(length), .gap(gap), .half_width(half_width),
        .press_enable(press_enable), .press_clean(press_clean), .man_offset(man_offset),
        .jump_height(jump_height), .score(score), .game_over(game_over),
        .next_platform(next_platform)
    );

    // Narrow-score copy fed the same stimulus, so saturation is reachable in a few hits.
    jump_controller #(.SCORE_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .press(press), .restart(restart), .frame_tick(frame_tick),
        .length(length), .gap(gap), .half_width(half_width),
        .press_enable(press_enable_s), .press_clean(press_clean_s), .man_offset(man_offset_s),
        .jump_height(jump_height_s), .score(score_s), .game_over(game_over_s),
        .next_platform(next_platform_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int gap;
        int tol;
        bit hit;
        int ticks;
    } vec_t;

    vec_t tbl[9];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_score = 0;
    int   exp_score_s = 0;

    task automatic check(input string nm, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: frames needed to cover the length, and the landing tolerance test.
    function automatic int ref_ticks(input int len);
        return (len + STEP - 1) / STEP;
    endfunction

    function automatic bit ref_hit(input int len, input int g, input int tol);
        int d;
        d = (len > g) ? len - g : g - len;
        return d <= tol;
    endfunction

    function automatic int ref_height(input int off, input int len);
        int m;
        m = (off < len - off) ? off : len - off;
        return m / 2;
    endfunction

    task automatic do_jump(input int len, input int g, input int tol,
                           input bit exp_hit, input int exp_ticks, input int tag);
        int off;
        length     = len[LEN_W-1:0];
        gap        = g[LEN_W-1:0];
        half_width = tol[LEN_W-1:0];
        press      = 1'b1;
        step();
        check("charge_en", tag, press_enable, 1);
        check("charge_clean", tag, press_clean, 0);
        press = 1'b0;
        step();
        check("release_en", tag, press_enable, 0);
        if (exp_ticks == 0) begin
            check("tap_clean", tag, press_clean, 1);
            check("tap_offset", tag, man_offset, 0);
            check("tap_score", tag, score, exp_score);
            return;
        end
        check("jump_clean", tag, press_clean, 0);
        for (int k = 1; k <= exp_ticks; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            off = (k * STEP < len) ? k * STEP : len;
            check("offset", tag, man_offset, off);
            check("height", tag, jump_height, ref_height(off, len));
            if (k < exp_ticks) begin
                step();
                check("offset_hold", tag, man_offset, off);
            end
        end
        check("land_np", tag, next_platform, 0);
        check("land_over", tag, game_over, 0);
        step();
        if (exp_hit) begin
            exp_score   = (exp_score == 65535) ? exp_score : exp_score + 1;
            exp_score_s = (exp_score_s == (1 << SAT_W) - 1) ? exp_score_s : exp_score_s + 1;
            check("hit_np", tag, next_platform, 1);
            check("hit_np_sat", tag, next_platform_s, 1);
            check("hit_over", tag, game_over, 0);
            check("hit_height", tag, jump_height, 0);
            step();
            check("score", tag, score, exp_score);
            check("score_sat", tag, score_s, exp_score_s);
            check("np_one_cycle", tag, next_platform, 0);
            check("idle_clean", tag, press_clean, 1);
            check("idle_offset", tag, man_offset, 0);
        end else begin
            check("miss_over", tag, game_over, 1);
            check("miss_clean", tag, press_clean, 1);
            check("miss_offset", tag, man_offset, len);
            check("miss_np", tag, next_platform, 0);
            press = 1'b1;
            step();
            step();
            press = 1'b0;
            check("over_press_en", tag, press_enable, 0);
            check("over_hold", tag, game_over, 1);
            restart = 1'b1;
            step();
            restart = 1'b0;
            exp_score   = 0;
            exp_score_s = 0;
            check("restart_over", tag, game_over, 0);
            check("restart_score", tag, score, 0);
            check("restart_offset", tag, man_offset, 0);
            check("restart_clean", tag, press_clean, 1);
        end
    endtask

    initial begin
        int len, g, tol;

        tbl[0] = '{len: 40,  gap: 40,  tol: 10, hit: 1'b1, ticks: 5};
        tbl[1] = '{len: 100, gap: 40,  tol: 10, hit: 1'b0, ticks: 13};
        tbl[2] = '{len: 30,  gap: 40,  tol: 10, hit: 1'b1, ticks: 4};
        tbl[3] = '{len: 29,  gap: 40,  tol: 10, hit: 1'b0, ticks: 4};
        tbl[4] = '{len: 0,   gap: 40,  tol: 10, hit: 1'b0, ticks: 0};
        tbl[5] = '{len: 800, gap: 795, tol: 5,  hit: 1'b1, ticks: 100};
        tbl[6] = '{len: 1,   gap: 0,   tol: 1,  hit: 1'b1, ticks: 1};
        tbl[7] = '{len: 7,   gap: 0,   tol: 6,  hit: 1'b0, ticks: 1};
        tbl[8] = '{len: 8,   gap: 8,   tol: 0,  hit: 1'b1, ticks: 1};

        #12;
        check("rst_en", 0, press_enable, 0);
        check("rst_clean", 0, press_clean, 1);
        check("rst_over", 0, game_over, 0);
        check("rst_np", 0, next_platform, 0);
        check("rst_height", 0, jump_height, 0);
        check("rst_offset", 0, man_offset, 0);
        check("rst_score", 0, score, 0);
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            do_jump(tbl[i].len, tbl[i].gap, tbl[i].tol, tbl[i].hit, tbl[i].ticks, i);
        end

        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        check("idle_restart_score", 0, score, exp_score);
        check("idle_restart_over", 0, game_over, 0);

        for (int r = 0; r < 40; r++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 800));
            g   = len + int'($urandom_range(0, 60)) - 30;
            if (g < 0) g = 0;
            tol = int'($urandom_range(0, 31));
            do_jump(len, g, tol, ref_hit(len, g, tol), ref_ticks(len), 100 + r);
        end

        length = 10'd100; gap = 10'd40; half_width = 10'd10;
        press = 1'b1;
        step();
        press = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        check("pre_reset_offset", 0, man_offset, 24);
        check("pre_reset_height", 0, jump_height, 12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_offset", 0, man_offset, 0);
        check("async_height", 0, jump_height, 0);
        check("async_clean", 0, press_clean, 1);
        check("async_en", 0, press_enable, 0);
        check("async_score", 0, score, 0);
        exp_score   = 0;
        exp_score_s = 0;
        #1;
        rst_n = 1'b1;
        step();

        for (int h = 0; h < 9; h++) begin
            do_jump(8, 8, 0, 1'b1, 1, 200 + h);
        end
        check("sat_final", 0, score_s, (1 << SAT_W) - 1);
        check("wide_final", 0, score, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jump_controller.md
Name: jump_controller

Overview:
- Game-flow sequencer for the press-to-jump mechanic.
- Drives the press-length accumulator's enable and clean inputs, and latches the final length when the button is released.
- Animates the jump horizontally, one step per video frame, then judges the landing against the next platform.
- Outputs the score, a game-over flag, and a request for a new platform; the display and platform generator consume these.

Parameters:
- STEP, 8, horizontal pixels advanced per frame_tick during a jump.
- LEN_W, 10, width of length, gap, tolerance and offset values.
- SCORE_W, 16, score counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- press  in  1  debounced button, synchronous to clk.
- restart  in  1  one-cycle pulse; leaves OVER.
- frame_tick  in  1  one-cycle pulse per video frame.
- length  in  LEN_W  charge length from the accumulator, saturating at 800.
- gap  in  LEN_W  distance to the next platform centre.
- half_width  in  LEN_W  landing tolerance.
- press_enable  out  1  accumulator enable.
- press_clean  out  1  accumulator clear.
- man_offset  out  LEN_W  horizontal displacement of the man during the jump.
- jump_height  out  LEN_W  vertical displacement of the man.
- score  out  SCORE_W  successful landings.
- game_over  out  1  high while in OVER.
- next_platform  out  1  one-cycle pulse after a hit.

Behaviour:
- States: IDLE, CHARGE, JUMP, LAND, SCORE, OVER; encoded in 3 bits.
- Reset (async, rst_n=0):
  - state=IDLE, offset=0, jump_len=0, gap_q=0, tol_q=0, score=0.
  - Outputs: press_enable=0, press_clean=1, game_over=0, next_platform=0, jump_height=0.
- IDLE:
  - press_clean=1, offset=0.
  - press=1 -> CHARGE.
- CHARGE:
  - press_enable=1, press_clean=0.
  - press=0 -> latch jump_len<=length, gap_q<=gap, tol_q<=half_width in the same cycle.
  - If length==0 (tap), go to IDLE; otherwise go to JUMP.
  - The accumulator only increments while press=1, so length in the release cycle is final.
- JUMP:
  - press_enable=0. frame_tick ignored in every other state.
  - On frame_tick: if offset+STEP >= jump_len, then offset<=jump_len and go to LAND; else offset<=offset+STEP.
  - The addition is LEN_W+1 bits wide, so it never wraps.
- LAND (1 cycle):
  - diff = |jump_len - gap_q|, computed LEN_W+1 bits signed.
  - diff <= tol_q is a hit -> SCORE. diff == tol_q counts as a hit. Otherwise -> OVER.
- SCORE (1 cycle):
  - score<=score+1, saturating at all-ones.
  - next_platform=1 for this cycle only.
  - -> IDLE.
- OVER:
  - game_over=1, press_clean=1; offset holds, so the man stays at the landing point.
  - press ignored. restart=1 -> score<=0, offset<=0, -> IDLE.
- jump_height: combinational from registers.
  - Value is min(offset, jump_len-offset)>>1 in JUMP and LAND; 0 in all other states.
- man_offset = offset register.
- Outputs are Moore functions of the state plus registers; no input-to-output combinational path.
- Reset mid-operation: immediate return to the reset values, regardless of state.
- restart outside OVER: ignored.

Decomposition:
- Shared game package:
  - state enum and encoding.
  - LEN_W, SCORE_W, MAX_LEN=800.
- Sub-module jump_judge: combinational abs-difference and tolerance compare (jump_len, gap_q, tol_q -> hit). Reusable by a future perfect-centre bonus.
- FSM, offset counter and score remain in jump_controller.

Test Plan (STEP=8, length driven by the accumulator model):
- Hold press so length=40, release; gap=40, half_width=10 -> JUMP lasts 5 frame_ticks (offset 8,16,24,32,40), LAND hit, score=1, next_platform high exactly 1 cycle, back in IDLE with press_clean=1.
- length=100, gap=40, half_width=10 -> offset reaches 100 after 13 ticks (the last clamped from 104), miss, game_over=1; press ignored; restart -> IDLE, score=0.
- length=30, gap=40, half_width=10 -> diff==tol, hit. length=29 with the same gap and tolerance -> miss.
- Press and release with the accumulator at length=0 -> IDLE directly, no JUMP, score unchanged.
- rst_n low mid-JUMP at offset=24 -> offset=0, state IDLE, jump_height=0 asynchronously, before the next clk edge.
- Preload score=16'hFFFF and land a hit -> score stays 16'hFFFF, next_platform still pulses.
